fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// Producer of the select lines for the operand-forwarding muxes feeding the ALU of the
//   pipelined MIPS core; the 32-bit 2:1/3:1 muxes consume fwd_a_sel/fwd_b_sel.
// Tracks in-flight register writes for the EX and MEM stages, including jal link
//   writes to $31. Raises stall for load-use hazards and inserts a bubble into EX.
// PARAMETERS
// REG_W     5   register-index width
// LINK_REG  31  destination index forced when id_link=1 (jal/jalr)
// PORTS
// clk          in   1      rising-edge clock
// rst_n        in   1      asynchronous active-low reset
// id_valid     in   1      ID-stage instruction valid
// id_rs        in   REG_W  source A index
// id_rt        in   REG_W  source B index
// id_use_rs    in   1      instruction reads rs
// id_use_rt    in   1      instruction reads rt
// id_wr_en     in   1      instruction writes a register
// id_wr_dst    in   REG_W  destination (rd or rt) when id_link=0
// id_link      in   1      destination is LINK_REG
// id_is_load   in   1      lw-class; result available only after MEM
// flush        in   1      branch/jump taken: kill the instruction entering EX
// fwd_a_sel    out  2      00 regfile, 01 EX/MEM result, 10 MEM/WB result
// fwd_b_sel    out  2      same encoding for operand B
// stall        out  1      hold PC and IF/ID; ID instruction is not accepted
// ex_busy      out  1      EX-stage slot holds a valid writer (debug/verification)
// BEHAVIOUR
// State: ex_{vld,wr,dst,load}, mem_{vld,wr,dst}. Async reset clears all; outputs reset to 0.
// Effective destination: eff_dst = id_link ? LINK_REG : id_wr_dst.
// Combinational (same cycle as the ID inputs), using current state:
//  - dep_ex_a = id_use_rs & ex_vld & ex_wr & ex_dst==id_rs & id_rs!=0; likewise mem, and for B.
//  - stall = id_valid & ex_load & (dep_ex_a | dep_ex_b).
//  - sel = 01 if dep_ex, else 10 if dep_mem, else 00 (EX has priority over MEM).
//  - No dependency on register 0: sel=00 always.
//  - id_valid=0: sels=00, stall=0.
// Sequential (each posedge clk):
//  - mem_* <= ex_* (advances unconditionally; MEM is never stalled).
//  - If stall or flush or !id_valid: ex_vld<=0, ex_wr<=0, ex_load<=0 (bubble).
//  - Else: ex_vld<=1, ex_wr<=id_wr_en, ex_dst<=eff_dst, ex_load<=id_is_load.
//  - A write with eff_dst==0 is tracked but never matches (rule above).
// Latency: load-use stall lasts exactly 1 cycle; the next cycle the load is in MEM and
//   the consumer receives sel=10.
// Simultaneous: flush and stall together -> bubble. Flush has no effect on stall output.
// Reset mid-operation: all tracking cleared asynchronously; sels and stall drop to 0 at
//   once, with no glitch dependence on clk.
// ex_busy = ex_vld & ex_wr.
// TESTING
// add $3 then add $4,$3,$3 next cycle -> fwd_a_sel=01, fwd_b_sel=01, stall=0
// add $3 ; nop ; sub $5,$3,$1 -> at sub, fwd_a_sel=10, fwd_b_sel=00
// lw $2 ; add $6,$2,$2 -> 1 cycle stall=1, bubble in EX; next cycle sels=10, stall=0
// jal (link) ; add $7,$31,$0 -> fwd_a_sel=01, fwd_b_sel=00; add with rs=0 never forwards
// add $3 in EX and add $3 in MEM, reader of $3 -> sel=01 (EX wins); flush -> next EX empty
// rst_n low mid-sequence during a stall -> stall=0, sels=00 immediately; first post-reset
//   reader of any register -> sel=00

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generator for the ALU input muxes.
// Tracks the writer held in the EX and MEM stages and compares it against the ID sources.
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_dst,
  input  logic             id_link,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             ex_busy
);

  localparam logic [REG_W-1:0] LINK_DST = REG_W'(LINK_REG);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } fwd_sel_e;

  logic             ex_vld, ex_wr, ex_load;
  logic [REG_W-1:0] ex_dst;
  logic             mem_vld, mem_wr;
  logic [REG_W-1:0] mem_dst;

  logic             dep_ex_a, dep_ex_b, dep_mem_a, dep_mem_b;
  logic [REG_W-1:0] eff_dst;
  logic             accept;

  assign eff_dst = id_link ? LINK_DST : id_wr_dst;

  // A source of $0 never matches, so a tracked write to $0 is harmless.
  assign dep_ex_a  = id_use_rs & ex_vld  & ex_wr  & (ex_dst  == id_rs) & (id_rs != '0);
  assign dep_ex_b  = id_use_rt & ex_vld  & ex_wr  & (ex_dst  == id_rt) & (id_rt != '0);
  assign dep_mem_a = id_use_rs & mem_vld & mem_wr & (mem_dst == id_rs) & (id_rs != '0);
  assign dep_mem_b = id_use_rt & mem_vld & mem_wr & (mem_dst == id_rt) & (id_rt != '0);

  assign stall   = id_valid & ex_load & (dep_ex_a | dep_ex_b);
  assign ex_busy = ex_vld & ex_wr;
  assign accept  = id_valid & ~stall & ~flush;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (id_valid) begin
      if (dep_ex_a)       fwd_a_sel = SEL_EXMEM;
      else if (dep_mem_a) fwd_a_sel = SEL_MEMWB;
      if (dep_ex_b)       fwd_b_sel = SEL_EXMEM;
      else if (dep_mem_b) fwd_b_sel = SEL_MEMWB;
    end
  end

  // MEM always advances; EX takes a bubble when the ID instruction is not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ex_vld  <= 1'b0;
      ex_wr   <= 1'b0;
      ex_load <= 1'b0;
      ex_dst  <= '0;
      mem_vld <= 1'b0;
      mem_wr  <= 1'b0;
      mem_dst <= '0;
    end else begin
      mem_vld <= ex_vld;
      mem_wr  <= ex_wr;
      mem_dst <= ex_dst;
      if (accept) begin
        ex_vld  <= 1'b1;
        ex_wr   <= id_wr_en;
        ex_dst  <= eff_dst;
        ex_load <= id_is_load;
      end else begin
        ex_vld  <= 1'b0;
        ex_wr   <= 1'b0;
        ex_load <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed pipeline scenarios with literal
// expectations, then randomized traffic compared every cycle against a slot-history model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_dst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0;
  logic       id_link = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  fwd_hazard_unit #(.REG_W(5), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_dst(id_wr_dst), .id_link(id_link), .id_is_load(id_is_load), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  // Model: history of the last two instruction slots, index 0 = youngest (EX), 1 = MEM.
  typedef struct packed {
    bit       vld;
    bit       wr;
    bit [4:0] dst;
    bit       load;
  } slot_t;

  slot_t hist [2];

  initial begin
    hist[0] = '0;
    hist[1] = '0;
  end

  // Age of the youngest in-flight writer of r: 1 = EX, 2 = MEM, 0 = none.
  function automatic int writer_age(input bit use_r, input bit [4:0] r);
    if (!use_r || r == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hist[k].vld && hist[k].wr && hist[k].dst == r) return k + 1;
    return 0;
  endfunction

  function automatic int exp_a();
    return id_valid ? writer_age(id_use_rs, id_rs) : 0;
  endfunction

  function automatic int exp_b();
    return id_valid ? writer_age(id_use_rt, id_rt) : 0;
  endfunction

  function automatic int exp_stall();
    return (id_valid && hist[0].load &&
            (writer_age(id_use_rs, id_rs) == 1 || writer_age(id_use_rt, id_rt) == 1)) ? 1 : 0;
  endfunction

  function automatic slot_t next_slot();
    if (id_valid && exp_stall() == 0 && !flush)
      return '{vld: 1'b1, wr: id_wr_en, dst: (id_link ? 5'd31 : id_wr_dst), load: id_is_load};
    return '{vld: 1'b0, wr: 1'b0, dst: hist[0].dst, load: 1'b0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] <= '0;
      hist[1] <= '0;
    end else begin
      hist[1] <= hist[0];
      hist[0] <= next_slot();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_fwd_a", int'(fwd_a_sel), exp_a());
      check("cyc_fwd_b", int'(fwd_b_sel), exp_b());
      check("cyc_stall", int'(stall), exp_stall());
      check("cyc_ex_busy", int'(ex_busy), (hist[0].vld && hist[0].wr) ? 1 : 0);
    end
  end

  task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int dst, input bit lnk, input bit ld, input bit fl);
    @(posedge clk);
    #1;
    id_valid = v;   id_rs = 5'(rs);  id_rt = 5'(rt);
    id_use_rs = urs; id_use_rt = urt; id_wr_en = wr; id_wr_dst = 5'(dst);
    id_link = lnk;  id_is_load = ld; flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lit(input string name, input int a, input int b, input int s);
    #2;
    check({name, "_a"}, int'(fwd_a_sel), a);
    check({name, "_b"}, int'(fwd_b_sel), b);
    check({name, "_stall"}, int'(stall), s);
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #12;
    check("reset_a", int'(fwd_a_sel), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_busy", int'(ex_busy), 0);
    @(negedge clk) rst_n = 1'b1;

    // add $3 ; add $4,$3,$3
    issue(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
    issue(1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
    lit("ex_fwd", 1, 1, 0);

    // add $3 ; nop ; sub $5,$3,$1
    idle(2);
    issue(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
    idle(1);
    issue(1, 3, 1, 1, 1, 1, 5, 0, 0, 0);
    lit("mem_fwd", 2, 0, 0);

    // lw $2 ; add $6,$2,$2 held for the stall cycle
    idle(2);
    issue(1, 1, 0, 1, 0, 1, 2, 0, 1, 0);
    issue(1, 2, 2, 1, 1, 1, 6, 0, 0, 0);
    lit("lu_stall", 1, 1, 1);
    issue(1, 2, 2, 1, 1, 1, 6, 0, 0, 0);
    lit("lu_after", 2, 2, 0);
    check("lu_bubble_busy", int'(ex_busy), 0);

    // jal (link, raw dst ignored) ; add $7,$31,$0
    idle(2);
    issue(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    issue(1, 31, 0, 1, 1, 1, 7, 0, 0, 0);
    lit("link_fwd", 1, 0, 0);

    // two writers of $3: EX wins; then a flushed writer of $8 leaves EX empty
    idle(2);
    issue(1, 1, 1, 1, 1, 1, 3, 0, 0, 0);
    issue(1, 1, 1, 1, 1, 1, 3, 0, 0, 0);
    issue(1, 3, 0, 1, 1, 1, 5, 0, 0, 0);
    lit("ex_prio", 1, 0, 0);
    issue(1, 0, 0, 1, 1, 1, 8, 0, 0, 1);
    issue(1, 8, 5, 1, 1, 1, 9, 0, 0, 0);
    lit("flush_empty", 0, 2, 0);
    check("flush_busy", int'(ex_busy), 0);

    // flush alongside a load-use stall: stall output unaffected
    idle(2);
    issue(1, 1, 0, 1, 0, 1, 2, 0, 1, 0);
    issue(1, 2, 0, 1, 0, 1, 6, 0, 0, 1);
    lit("flush_stall", 1, 0, 1);
    issue(1, 2, 0, 1, 0, 1, 6, 0, 0, 0);
    lit("flush_stall_after", 2, 0, 0);

    // asynchronous reset in the middle of a stall
    idle(2);
    issue(1, 1, 0, 1, 0, 1, 2, 0, 1, 0);
    issue(1, 2, 2, 1, 1, 1, 6, 0, 0, 0);
    lit("pre_rst", 1, 1, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", int'(stall), 0);
    check("rst_mid_a", int'(fwd_a_sel), 0);
    check("rst_mid_b", int'(fwd_b_sel), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(1, 2, 31, 1, 1, 1, 4, 0, 0, 0);
    lit("post_rst", 0, 0, 0);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      issue($urandom_range(0, 9) < 8, rnd_reg(), rnd_reg(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rnd_reg(),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #6 rst_n = 1'b1;
      end
    end

    idle(1);
    @(posedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
